lzrw1_decompressor: RTL and testbench
=====================================

// Module: lzrw1_decompressor
// PURPOSE
//  Streaming LZRW1 decoder; the inverse of the compressor datapath.
//  - Consumes the item stream: literal = ctrl 0 + 1 byte; copy = ctrl 1 + 2 bytes.
//  - Rebuilds the original byte string through a 4 KB history window.
//  - Sits between compressed-memory readback and the consumer; valid/ready on both sides.
// PARAMETERS
//  HISTSIZE  4096  history depth in bytes; power of two, >= 4096 (12-bit offsets)
//  CNT_W     32    width of the out_count byte counter
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high
//  start      in   1      pulse: begin new block; honoured only in IDLE/DONE/ERR
//  in_valid   in   1      input byte valid
//  in_ready   out  1      input byte accepted when in_valid & in_ready
//  in_byte    in   8      compressed byte
//  in_ctrl    in   1      control bit; sampled on an item's first byte only
//  in_last    in   1      final byte of the compressed stream
//  out_valid  out  1      decompressed byte valid
//  out_ready  in   1      consumer accepts byte
//  out_byte   out  8      decompressed byte
//  out_last   out  1      qualifies the final decompressed byte
//  done       out  1      block complete, last byte consumed
//  error      out  1      sticky malformed-stream flag
//  out_count  out  CNT_W  bytes emitted since start
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; wptr 0.
//  Copy encoding:
//  - byte0 = {len_f[3:0], off[11:8]}; byte1 = off[7:0].
//  - Copy length = len_f+1, legal range 3..16.
//  Output register: advances when !out_valid | out_ready (stall signal "adv").
//  in_ready = (state==HEAD | state==OFFLO) & adv.
//  FSM:
//  - IDLE: start -> HEAD; clears wptr, out_count, done, error.
//  - HEAD, ctrl=0: out_byte<=in_byte; history[wptr]<=in_byte; wptr++; out_count++.
//    Then DONE if in_last (out_last=1), else HEAD.
//  - HEAD, ctrl=1: latch len_f and off_hi.
//    If in_last -> ERR (truncated item), else OFFLO.
//  - OFFLO: latch off_lo and the last flag.
//    ERR if off==0, len_f<2, or off>out_count while out_count<HISTSIZE.
//    Otherwise COPY with rem=len_f+1.
//  - COPY: on each adv cycle: out_byte<=history[(wptr-off) mod HISTSIZE]; write that byte at wptr; wptr++; rem--.
//    After the rem==1 beat: DONE if last (out_last on that beat), else HEAD.
//  - DONE: done = !out_valid; holds until start.
//  - ERR: error=1; in_ready=0; a pending out byte still drains; exit only by start or reset.
//  Latency and throughput:
//  - Literal: byte on out 1 cycle after input handshake.
//  - Copy: first byte 2 cycles after the OFFLO handshake; then 1 byte/cycle while out_ready.
//  Overlap: off < length is legal (run-length). History is read combinationally, so a byte written on cycle n is readable on n+1.
//  Wrap: wptr is log2(HISTSIZE) bits and wraps silently; read index is taken modulo HISTSIZE.
//  out_count wraps at 2^CNT_W.
//  Backpressure: out_ready=0 freezes state, wptr, rem and history; no byte lost or duplicated.
//  start outside IDLE/DONE/ERR is ignored.
//  Reset mid-item aborts immediately to reset values.
// CONFIGURATION
//  LZRW1_DECOMP_STATS_EN defined:
//  - Adds outputs lit_items[CNT_W] and copy_items[CNT_W].
//  - Each increments on its item's completing handshake; cleared by reset/start.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package lzrw1_pkg:
//  - dstate_t enum {IDLE,HEAD,OFFLO,COPY,DONE,ERR}.
//  - Constants OFFSET_W=12, LEN_W=4, MIN_MATCH=3, MAX_MATCH=16.
//  - copy_hdr_t packed struct {len_f, off_hi}.
//  Sub-module lzrw1_dhistory:
//  - HISTSIZE x 8 register array, 1 write port, 1 combinational read port.
//  - Writes cleared of meaning by start (valid range tracked via out_count).
// TESTING
//  1 Literals 'A','B','C' (ctrl 0, last on 'C') -> out A,B,C; out_last with C; done=1; out_count=3.
//  2 Literals a,b,c then copy {0x20,0x03} (len 3, off 3), last -> out "abcabc"; out_count=6.
//  3 Literal 'x' then copy {0x40,0x01} (len 5, off 1) -> "xxxxxx"; overlap correct.
//  4 Errors, each -> error=1, in_ready=0; start clears error:
//    first item copy off 1 at out_count 0; copy with len_f=1; ctrl=1 byte carrying in_last.
//  5 Random 50% out_ready during a 16-byte copy; mid-copy reset -> sequence matches model; reset gives all-zero outputs, IDLE.
//  6 Wrap: 4100 literals then copy off 4095 len 16 -> bytes equal positions 5..20 of the stream.

Source files
------------

// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 decompressor.
package lzrw1_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAD  = 3'd1,
    OFFLO = 3'd2,
    COPY  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } dstate_t;

  localparam int OFFSET_W  = 12;
  localparam int LEN_W     = 4;
  localparam int MIN_MATCH = 3;
  localparam int MAX_MATCH = 16;

  typedef struct packed {
    logic [LEN_W-1:0]    len_f;
    logic [OFFSET_W-9:0] off_hi;
  } copy_hdr_t;

endpackage

// File: rtl/lzrw1_dhistory.sv
// History window: register array with one write port and one combinational read port.
module lzrw1_dhistory #(
  parameter int HISTSIZE = 4096,
  parameter int AW       = 12
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_r [HISTSIZE];

  // write port; contents need no reset since out_count bounds the readable range
  always_ff @(posedge clock) begin
    if (we) mem_r[waddr] <= wdata;
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/lzrw1_decompressor.sv
// Streaming LZRW1 decoder with valid/ready on both sides.
// Optional item counters are enabled by defining LZRW1_DECOMP_STATS_EN.
module lzrw1_decompressor
  import lzrw1_pkg::*;
#(
  parameter int HISTSIZE = 4096,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_ctrl,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] out_count
`ifdef LZRW1_DECOMP_STATS_EN
  ,
  output logic [CNT_W-1:0] lit_items,
  output logic [CNT_W-1:0] copy_items
`endif
);

  localparam int AW    = $clog2(HISTSIZE);
  localparam int REM_W = $clog2(MAX_MATCH + 1);

  dstate_t          state_r, stateNext_s;
  logic [AW-1:0]    wptr_r;
  copy_hdr_t        hdr_r;
  logic [7:0]       offLo_r;
  logic             copyLast_r;
  logic [REM_W-1:0] rem_r;
  logic             outValid_r, outLast_r;
  logic [7:0]       outByte_r;
  logic [CNT_W-1:0] outCount_r;

  logic                adv_s, inReady_s, inFire_s, litFire_s, hdrFire_s, offFire_s;
  logic                copyBeat_s, badCopy_s, startOk_s;
  logic [OFFSET_W-1:0] off_s, offIn_s;
  logic [AW-1:0]       histRa_s;
  logic [7:0]          histRd_s, histWd_s;
  logic                histWe_s;

  assign adv_s      = !outValid_r || out_ready;
  assign inFire_s   = in_valid && inReady_s;
  assign litFire_s  = inFire_s && (state_r == HEAD) && !in_ctrl;
  assign hdrFire_s  = inFire_s && (state_r == HEAD) && in_ctrl;
  assign offFire_s  = inFire_s && (state_r == OFFLO);
  assign copyBeat_s = (state_r == COPY) && adv_s;
  assign startOk_s  = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));

  assign off_s   = {hdr_r.off_hi, offLo_r};
  assign offIn_s = {hdr_r.off_hi, in_byte};
  // a copy may not reach before the start of the block until the window has filled once
  assign badCopy_s = (offIn_s == OFFSET_W'(0))
                  || (hdr_r.len_f < LEN_W'(MIN_MATCH - 1))
                  || ((outCount_r < CNT_W'(HISTSIZE)) && (CNT_W'(offIn_s) > outCount_r));

  assign histRa_s = wptr_r - AW'(off_s);
  assign histWe_s = litFire_s || copyBeat_s;
  assign histWd_s = litFire_s ? in_byte : histRd_s;

  lzrw1_dhistory #(.HISTSIZE(HISTSIZE), .AW(AW)) uHistory (
    .clock (clock),
    .we    (histWe_s),
    .waddr (wptr_r),
    .wdata (histWd_s),
    .raddr (histRa_s),
    .rdata (histRd_s)
  );

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= stateNext_s;
  end

  // FSM next-state logic
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (start) stateNext_s = HEAD;
        else       stateNext_s = state_r;
      end
      HEAD: begin
        if (litFire_s)      stateNext_s = in_last ? DONE : HEAD;
        else if (hdrFire_s) stateNext_s = in_last ? ERR : OFFLO;
        else                stateNext_s = HEAD;
      end
      OFFLO: begin
        if (offFire_s) stateNext_s = badCopy_s ? ERR : COPY;
        else           stateNext_s = OFFLO;
      end
      COPY: begin
        if (copyBeat_s && (rem_r == REM_W'(1))) stateNext_s = copyLast_r ? DONE : HEAD;
        else                                    stateNext_s = COPY;
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    inReady_s = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state_r)
      HEAD, OFFLO: inReady_s = adv_s;
      DONE:        done      = !outValid_r;
      ERR:         error     = 1'b1;
      default:     inReady_s = 1'b0;
    endcase
  end

  // datapath: output register, write pointer, copy header and byte counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid_r <= 1'b0;
      outLast_r  <= 1'b0;
      outByte_r  <= 8'd0;
      outCount_r <= '0;
      wptr_r     <= '0;
      hdr_r      <= '0;
      offLo_r    <= 8'd0;
      copyLast_r <= 1'b0;
      rem_r      <= '0;
    end else begin
      if (adv_s) begin
        outValid_r <= 1'b0;
        outLast_r  <= 1'b0;
      end
      if (histWe_s) begin
        outValid_r <= 1'b1;
        outByte_r  <= histWd_s;
        outLast_r  <= litFire_s ? in_last : (copyLast_r && (rem_r == REM_W'(1)));
        wptr_r     <= wptr_r + AW'(1);
        outCount_r <= outCount_r + CNT_W'(1);
      end
      if (copyBeat_s) rem_r <= rem_r - REM_W'(1);
      if (hdrFire_s)  hdr_r <= copy_hdr_t'(in_byte);
      if (offFire_s) begin
        offLo_r    <= in_byte;
        copyLast_r <= in_last;
        rem_r      <= REM_W'(hdr_r.len_f) + REM_W'(1);
      end
      if (startOk_s) begin
        wptr_r     <= '0;
        outCount_r <= '0;
      end
    end
  end

`ifdef LZRW1_DECOMP_STATS_EN
  // item counters, bumped on each item's completing handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lit_items  <= '0;
      copy_items <= '0;
    end else if (startOk_s) begin
      lit_items  <= '0;
      copy_items <= '0;
    end else begin
      if (litFire_s)               lit_items  <= lit_items + CNT_W'(1);
      if (offFire_s && !badCopy_s) copy_items <= copy_items + CNT_W'(1);
    end
  end
`endif

  assign in_ready  = inReady_s;
  assign out_valid = outValid_r;
  assign out_byte  = outByte_r;
  assign out_last  = outLast_r;
  assign out_count = outCount_r;

endmodule

// File: tb/tb_lzrw1_decompressor.sv
// Self-checking bench: a byte-stream reference model predicts every output byte.
module tb_lzrw1_decompressor;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_ready, in_ctrl, in_last;
  logic        out_valid, out_ready, out_last, done, error;
  logic [7:0]  in_byte, out_byte;
  logic [31:0] out_count;
`ifdef LZRW1_DECOMP_STATS_EN
  logic [31:0] lit_items, copy_items;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] stream[$];
  logic [8:0] expQ[$];
  logic [7:0] got[$];
  logic [8:0] cmpE;
  bit         rndMode = 1'b0;

  always #5 clock = ~clock;

  lzrw1_decompressor dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .in_ctrl(in_ctrl), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .done(done), .error(error), .out_count(out_count)
`ifdef LZRW1_DECOMP_STATS_EN
    , .lit_items(lit_items), .copy_items(copy_items)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // out_ready changes just after the rising edge so it is stable across each cycle
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = rndMode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // compare every accepted output byte against the model's expectation queue
  initial forever begin
    @(negedge clock);
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0h expected=none", out_byte);
      end else begin
        cmpE = expQ.pop_front();
        check("out_byte", {24'd0, out_byte}, {24'd0, cmpE[7:0]});
        check("out_last", {31'd0, out_last}, {31'd0, cmpE[8]});
        got.push_back(out_byte);
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic c, input logic l);
    int n = 0;
    in_valid = 1'b1; in_byte = b; in_ctrl = c; in_last = l;
    #1;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
    end
    @(negedge clock);
    in_valid = 1'b0; in_ctrl = 1'b0; in_last = 1'b0;
  endtask

  task automatic lit(input logic [7:0] b, input logic l);
    stream.push_back(b);
    expQ.push_back({l, b});
    sendByte(b, 1'b0, l);
  endtask

  task automatic cpy(input int len, input int off, input logic l);
    logic [7:0] b;
    logic [7:0] hdr;
    for (int i = 0; i < len; i++) begin
      b = stream[stream.size() - off];
      stream.push_back(b);
      expQ.push_back({l && (i == len - 1), b});
    end
    hdr = {4'(len - 1), 4'(off >> 8)};
    sendByte(hdr, 1'b1, 1'b0);
    sendByte(8'(off), 1'b0, l);
  endtask

  task automatic startBlock();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    stream.delete();
    got.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || out_valid === 1'b1) && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (n >= 600) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout actual=%0d expected=0", name, expQ.size());
    end
    @(negedge clock);
  endtask

  task automatic checkGot(input string name, input string s);
    check({name, "_len"}, got.size(), s.len());
    for (int i = 0; i < s.len() && i < got.size(); i++)
      check(name, {24'd0, got[i]}, {24'd0, s[i]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'd0; in_ctrl = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_byte", {24'd0, out_byte}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_out_count", out_count, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // plain literals
    startBlock();
    lit("A", 1'b0); lit("B", 1'b0); lit("C", 1'b1);
    drain("t1");
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_count", out_count, 32'd3);
    checkGot("t1_str", "ABC");
`ifdef LZRW1_DECOMP_STATS_EN
    check("t1_lit_items", lit_items, 32'd3);
`endif

    // back-reference copy
    startBlock();
    lit("a", 1'b0); lit("b", 1'b0); lit("c", 1'b0);
    cpy(3, 3, 1'b1);
    drain("t2");
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_count", out_count, 32'd6);
    checkGot("t2_str", "abcabc");

    // overlapping copy acts as run-length
    startBlock();
    lit("x", 1'b0);
    cpy(5, 1, 1'b1);
    drain("t3");
    check("t3_count", out_count, 32'd6);
    checkGot("t3_str", "xxxxxx");

    // malformed streams
    startBlock();
    sendByte(8'h20, 1'b1, 1'b0); sendByte(8'h01, 1'b0, 1'b0);
    check("t4a_error", {31'd0, error}, 32'd1);
    check("t4a_in_ready", {31'd0, in_ready}, 32'd0);
    startBlock();
    check("t4a_cleared", {31'd0, error}, 32'd0);
    check("t4a_ready_again", {31'd0, in_ready}, 32'd1);
    lit("q", 1'b0);
    sendByte(8'h10, 1'b1, 1'b0); sendByte(8'h01, 1'b0, 1'b0);
    drain("t4b");
    check("t4b_error", {31'd0, error}, 32'd1);
    check("t4b_in_ready", {31'd0, in_ready}, 32'd0);
    startBlock();
    sendByte(8'h20, 1'b1, 1'b1);
    check("t4c_error", {31'd0, error}, 32'd1);
    check("t4c_in_ready", {31'd0, in_ready}, 32'd0);
    startBlock();
    check("t4c_cleared", {31'd0, error}, 32'd0);

    // random backpressure over a 16-byte copy
    rndMode = 1'b1;
    startBlock();
    for (int i = 0; i < 5; i++) lit(8'(8'h30 + i), 1'b0);
    cpy(16, 3, 1'b1);
    drain("t5");
    check("t5_count", out_count, 32'd21);
    check("t5_done", {31'd0, done}, 32'd1);

    // reset in the middle of a copy
    startBlock();
    lit("k", 1'b0); lit("l", 1'b0); lit("m", 1'b0);
    cpy(16, 2, 1'b0);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    @(negedge clock);
    expQ.delete();
    check("t5r_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5r_out_byte", {24'd0, out_byte}, 32'd0);
    check("t5r_out_last", {31'd0, out_last}, 32'd0);
    check("t5r_count", out_count, 32'd0);
    check("t5r_in_ready", {31'd0, in_ready}, 32'd0);
    check("t5r_done", {31'd0, done}, 32'd0);
    check("t5r_error", {31'd0, error}, 32'd0);
    rndMode = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // window wrap: copy from 4095 back after 4100 literals
    startBlock();
    for (int i = 0; i < 4100; i++) lit(8'(i * 7 + 3), 1'b0);
    cpy(16, 4095, 1'b1);
    drain("t6");
    check("t6_count", out_count, 32'd4116);
    check("t6_first", {24'd0, got[4100]}, 32'd38);
    check("t6_lastb", {24'd0, got[4115]}, 32'd143);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
